// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked multi-cycle ALU for the MIPS core.
// AND/OR/ADD/SUB/SLT and reserved opcodes take one cycle. MULT uses an
// iterative shift-add engine that yields the full 2*WIDTH product.
// Optional feature macro: ALU_DIV_EN adds opcode 111 = DIVU, an iterative
// restoring divider. Without it, 111 is a reserved opcode.
module alu_multicycle #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             illegal
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_DIV_EN
        S_DIV  = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mplier;     // multiplier bits, or quotient while dividing
    logic [2*WIDTH-1:0] mcand;      // multiplicand, shifted left each step
    logic [2*WIDTH-1:0] acc;        // running product
    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0]   sc_lo;
    logic               sc_illegal;
    logic [WIDTH-1:0]   done_lo;
    logic [WIDTH-1:0]   done_hi;
    logic               accept;

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   rem;
    logic               op_div;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     div_diff;

    // One restoring-division step; div_diff[WIDTH] set means the trial subtract borrowed.
    // A zero divisor never borrows, so the quotient fills with ones and rem ends equal to a.
    assign rem_shift = {rem, mplier[WIDTH-1]};
    assign div_diff  = rem_shift - {1'b0, divisor};
    assign done_lo   = op_div ? mplier : acc[WIDTH-1:0];
    assign done_hi   = op_div ? rem    : acc[2*WIDTH-1:WIDTH];
`else
    assign done_lo   = acc[WIDTH-1:0];
    assign done_hi   = acc[2*WIDTH-1:WIDTH];
`endif

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle results, computed straight from the offered operands.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sc_lo      = '0;
        sc_illegal = 1'b0;
        case (alu_ctrl)
            3'b000:  sc_lo = src_a & src_b;
            3'b001:  sc_lo = src_a | src_b;
            3'b010:  sc_lo = src_a + src_b;
            3'b100:  sc_lo = src_a - src_b;
            3'b110:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            // 011 and (without the divider) 111 land here; MULT/DIVU never use this path.
            default: sc_illegal = 1'b1;
        endcase
    end

    // Shift-add step: add the multiplicand for each of the MUL_STEP low multiplier bits.
    always_comb begin
        mul_sum = acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) mul_sum = mul_sum + (mcand << j);
        end
    end

    // Control FSM, iterative datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mplier    <= '0;
            mcand     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_DIV_EN
            divisor   <= '0;
            rem       <= '0;
            op_div    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            // Drain first; a same-edge load below re-asserts out_valid.
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (alu_ctrl == 3'b101) begin
                            state  <= S_MUL;
                            cnt    <= CW'(STEPS);
                            mplier <= src_a;
                            mcand  <= {{WIDTH{1'b0}}, src_b};
                            acc    <= '0;
`ifdef ALU_DIV_EN
                            op_div <= 1'b0;
                        end else if (alu_ctrl == 3'b111) begin
                            state   <= S_DIV;
                            cnt     <= CW'(WIDTH);
                            mplier  <= src_a;
                            divisor <= src_b;
                            rem     <= '0;
                            op_div  <= 1'b1;
`endif
                        end else begin
                            out_valid <= 1'b1;
                            result    <= sc_lo;
                            result_hi <= '0;
                            zero      <= (sc_lo == '0);
                            illegal   <= sc_illegal;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_sum;
                    mplier <= mplier >> MUL_STEP;
                    mcand  <= mcand << MUL_STEP;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_DONE;
                end
`ifdef ALU_DIV_EN
                S_DIV: begin
                    mplier <= {mplier[WIDTH-2:0], ~div_diff[WIDTH]};
                    rem    <= div_diff[WIDTH] ? rem_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_DONE;
                end
`endif
                S_DONE: begin
                    out_valid <= 1'b1;
                    result    <= done_lo;
                    result_hi <= done_hi;
                    zero      <= (done_lo == '0);
                    illegal   <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (default WIDTH=32, MUL_STEP=1).
// Define ALU_DIV_EN for both bench and RTL to cover the DIVU opcode.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [2:0]   alu_ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         illegal;

    int nvec = 0;
    int nerr = 0;

    alu_multicycle #(.WIDTH(W), .MUL_STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Advance one clock; everything is driven and sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare a single-cycle result presented after the accept edge.
    task automatic chk_out(input string name, input logic [W-1:0] exp_lo,
                           input logic exp_zero, input logic exp_ill);
        nvec++;
        if (out_valid !== 1'b1) begin
            nerr++; $display("FAIL %s out_valid: got %b expected 1", name, out_valid);
        end
        nvec++;
        if (result !== exp_lo) begin
            nerr++; $display("FAIL %s result: got %h expected %h", name, result, exp_lo);
        end
        nvec++;
        if (result_hi !== '0) begin
            nerr++; $display("FAIL %s result_hi: got %h expected 0", name, result_hi);
        end
        nvec++;
        if (zero !== exp_zero || illegal !== exp_ill) begin
            nerr++; $display("FAIL %s flags: got zero=%b illegal=%b expected zero=%b illegal=%b",
                             name, zero, illegal, exp_zero, exp_ill);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src_a = '0; src_b = '0; alu_ctrl = 3'b000;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL reset handshake: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        nvec++;
        if (result !== '0 || result_hi !== '0 || illegal !== 1'b0 || zero !== 1'b0) begin
            nerr++; $display("FAIL reset outputs: got result=%h hi=%h zero=%b illegal=%b expected all 0",
                             result, result_hi, zero, illegal);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1; in_valid = 1'b1;
        src_a = 32'hFFFF_FFFF; src_b = 32'h1; alu_ctrl = 3'b010;
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL stream in_ready: got %b expected 1", in_ready);
        end
        tick();
        chk_out("add_wrap", 32'h0, 1'b1, 1'b0);
        src_a = 32'd5; src_b = 32'd7; alu_ctrl = 3'b100;
        tick();
        chk_out("sub_wrap", 32'hFFFF_FFFE, 1'b0, 1'b0);
        src_a = 32'hFFFF_FFFF; src_b = 32'h1; alu_ctrl = 3'b110;
        tick();
        chk_out("slt_neg", 32'h1, 1'b0, 1'b0);
        src_a = 32'h1; src_b = 32'hFFFF_FFFF; alu_ctrl = 3'b110;
        tick();
        chk_out("slt_pos", 32'h0, 1'b1, 1'b0);
        src_a = 32'hF0F0_0000; src_b = 32'h0000_0F0F; alu_ctrl = 3'b001;
        tick();
        chk_out("or", 32'hF0F0_0F0F, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL stream drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    // Issue a MULT/DIVU, count clocks to out_valid and check the full result.
    task automatic run_long(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] op, input int lat,
                            input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
        int cyc;
        bit busy_ready;
        out_ready = 1'b1; in_valid = 1'b1;
        src_a = a; src_b = b; alu_ctrl = op;
        tick();
        in_valid = 1'b0;
        src_a = ~a; src_b = ~b;
        cyc = 0;
        busy_ready = 1'b0;
        while (!out_valid && cyc < lat + 10) begin
            if (in_ready) busy_ready = 1'b1;
            tick();
            cyc++;
        end
        nvec++;
        if (cyc !== lat) begin
            nerr++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, lat);
        end
        nvec++;
        if (busy_ready) begin
            nerr++; $display("FAIL %s busy in_ready: got 1 expected 0", name);
        end
        nvec++;
        if (result !== exp_lo || result_hi !== exp_hi) begin
            nerr++; $display("FAIL %s value: got %h_%h expected %h_%h", name, result_hi, result, exp_hi, exp_lo);
        end
        nvec++;
        if (illegal !== 1'b0 || zero !== (exp_lo == '0)) begin
            nerr++; $display("FAIL %s flags: got zero=%b illegal=%b expected zero=%b illegal=0",
                             name, zero, illegal, (exp_lo == '0));
        end
        tick();
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL %s drain: got out_valid=%b expected 0", name, out_valid);
        end
    endtask

    task automatic test_mult();
        run_long("mult_ff_2", 32'hFFFF_FFFF, 32'h2, 3'b101, 33, 32'hFFFF_FFFE, 32'h1);
        run_long("mult_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 33, 32'h0000_0001, 32'hFFFF_FFFE);
        run_long("mult_zero", 32'h1234_5678, 32'h0, 3'b101, 33, 32'h0, 32'h0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        src_a = 32'h0000_0F0F; src_b = 32'h0000_00FF; alu_ctrl = 3'b000;
        tick();
        chk_out("and_bp", 32'h0000_000F, 1'b0, 1'b0);
        src_a = 32'd3; src_b = 32'd4; alu_ctrl = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if (out_valid !== 1'b1 || result !== 32'h0000_000F || in_ready !== 1'b0) begin
                nerr++; $display("FAIL bp_hold: got out_valid=%b result=%h in_ready=%b expected 1 0000000f 0",
                                 out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL bp_release in_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        chk_out("bp_drain_accept", 32'd7, 1'b0, 1'b0);
        tick();
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL bp_final drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reserved();
        out_ready = 1'b1; in_valid = 1'b1;
        src_a = 32'hFFFF_FFFF; src_b = 32'h1; alu_ctrl = 3'b011;
        tick();
        in_valid = 1'b0;
        chk_out("rsv_011", 32'h0, 1'b1, 1'b1);
        tick();
`ifdef ALU_DIV_EN
        run_long("divu_100_7", 32'd100, 32'd7, 3'b111, 33, 32'd14, 32'd2);
        run_long("divu_by_0", 32'h0000_1234, 32'h0, 3'b111, 33, 32'hFFFF_FFFF, 32'h0000_1234);
`else
        in_valid = 1'b1;
        src_a = 32'd100; src_b = 32'd7; alu_ctrl = 3'b111;
        tick();
        in_valid = 1'b0;
        chk_out("rsv_111", 32'h0, 1'b1, 1'b1);
        tick();
`endif
    endtask

    task automatic test_reset_abort();
        bit seen;
        out_ready = 1'b1; in_valid = 1'b1;
        src_a = 32'd3; src_b = 32'd5; alu_ctrl = 3'b101;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #2;
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL abort in reset: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        nvec++;
        if (seen) begin
            nerr++; $display("FAIL abort result: got out_valid=1 expected 0");
        end
        in_valid = 1'b1;
        src_a = 32'd2; src_b = 32'd3; alu_ctrl = 3'b010;
        tick();
        in_valid = 1'b0;
        chk_out("add_after_abort", 32'd5, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_mult();
        test_backpressure();
        test_reserved();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
